// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through a DV/Done launch handshake.
// Define UART_TX_FIFO_OVF_FLAG_EN to build the sticky write-when-full flag on o_Overflow.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_TX_Done,
  output logic                  o_Overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

  logic [7:0]          mem_q [Depth];
  logic [DEPTH_LOG2:0] wp_q, wp_d, rp_q, rp_d;
  state_e              state_q, state_d;
  logic                tx_dv_q, tx_dv_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                full, empty, wr_en, pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                 (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);
  assign wr_en = i_Wr_DV & ~full;
  assign pop   = (state_q == StIdle) & ~empty;

  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    if (wr_en) begin
      wp_d = wp_q + PtrOne;
    end
    case (state_q)
      StIdle: begin
        if (pop) begin
          tx_byte_d = mem_q[rp_q[DEPTH_LOG2-1:0]];
          tx_dv_d   = 1'b1;
          rp_d      = rp_q + PtrOne;
          state_d   = StLaunch;
        end
      end
      StLaunch:   state_d = StWaitDone;
      StWaitDone: if (i_TX_Done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wp_q      <= '0;
      rp_q      <= '0;
      state_q   <= StIdle;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      mem_q[wp_q[DEPTH_LOG2-1:0]] <= i_Wr_Byte;
    end
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (i_Wr_DV & full);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_Overflow = ovf_q;
`else
  assign o_Overflow = 1'b0;
`endif

  assign o_Full    = full;
  assign o_Empty   = empty;
  assign o_Count   = wp_q - rp_q;
  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH_LOG2=2) with a behavioural transmitter that
// answers each launch with a Done pulse and scoreboards the launched bytes.
module tb_uart_tx_fifo;

  localparam int TxCyc = 20;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  localparam logic ExpOvf = 1'b1;
`else
  localparam logic ExpOvf = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       tx_done = 1'b0;
  logic       full, empty, tx_dv, ovf;
  logic [2:0] count;
  logic [7:0] tx_byte;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  bit   hold_done = 1'b0;
  bit   busy = 1'b0;
  bit   prev_dv = 1'b0;
  bit   check_gap = 1'b0;
  bit   had_done = 1'b0;
  int   cnt = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   max_cnt = 0;

  uart_tx_fifo #(.DEPTH_LOG2(2)) dut (
    .i_Clock   (clk),
    .i_Rst_L   (rst_l),
    .i_Wr_DV   (wr_dv),
    .i_Wr_Byte (wr_byte),
    .o_Full    (full),
    .o_Empty   (empty),
    .o_Count   (count),
    .o_TX_DV   (tx_dv),
    .o_TX_Byte (tx_byte),
    .i_TX_Done (tx_done),
    .o_Overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: launch starts a TxCyc-cycle frame, then Done pulses for one cycle.
  always @(negedge clk) begin
    cyc++;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    tx_done = 1'b0;
    if (tx_dv) begin
      chk("dv_spacing", {31'd0, prev_dv}, 0);
      chk("launch_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      if (check_gap && had_done) chk("launch_gap", cyc - done_cyc, 2);
      had_done = 1'b0;
      busy = 1'b1;
      cnt = TxCyc;
    end else if (busy && !hold_done) begin
      if (cnt == 0) begin
        tx_done = 1'b1;
        busy = 1'b0;
        had_done = 1'b1;
        done_cyc = cyc;
      end else begin
        cnt--;
      end
    end
    prev_dv = tx_dv;
  end

  task automatic wr(input logic [7:0] b);
    @(posedge clk); #1;
    wr_dv = 1'b1;
    wr_byte = b;
    exp_q.push_back(b);
    @(posedge clk); #1;
    wr_dv = 1'b0;
  endtask

  task automatic burst(input logic [7:0] first, input logic [7:0] step, input int n,
                       input int n_push);
    logic [7:0] b;
    b = first;
    @(posedge clk); #1;
    wr_dv = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_byte = b;
      if (i < n_push) exp_q.push_back(b);
      b = b + step;
      @(posedge clk); #1;
    end
    wr_dv = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && empty && !busy && !tx_dv) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, exp_q.size() == 0 && empty && !busy && !tx_dv}, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset values while held in reset.
    #2;
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_tx_dv", {31'd0, tx_dv}, 0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    #10 rst_l = 1'b1;

    // Single byte: accepted at edge k, popped at k+1.
    @(posedge clk); #1;
    wr_dv = 1'b1;
    wr_byte = 8'h3A;
    exp_q.push_back(8'h3A);
    @(posedge clk); #1;
    wr_dv = 1'b0;
    @(negedge clk);
    chk("single_count_k", {29'd0, count}, 1);
    chk("single_dv_k", {31'd0, tx_dv}, 0);
    @(negedge clk);
    chk("single_dv_k1", {31'd0, tx_dv}, 1);
    chk("single_byte_k1", {24'd0, tx_byte}, 32'h3A);
    chk("single_empty_k1", {31'd0, empty}, 1);
    @(negedge clk);
    chk("single_dv_k2", {31'd0, tx_dv}, 0);
    wait_drained("single_drain", 200);

    // Burst of four with launch-after-done spacing checked.
    had_done = 1'b0;
    check_gap = 1'b1;
    max_cnt = 0;
    burst(8'h11, 8'h11, 4, 4);
    wait_drained("burst_drain", 400);
    check_gap = 1'b0;
    chk("burst_peak", max_cnt, 3);

    // Fill while the transmitter is stalled; A5 must be dropped.
    hold_done = 1'b1;
    burst(8'hA0, 8'h01, 6, 5);
    @(negedge clk);
    chk("full_flag", {31'd0, full}, 1);
    chk("full_count", {29'd0, count}, 4);
    chk("full_ovf", {31'd0, ovf}, {31'd0, ExpOvf});
    #1 hold_done = 1'b0;
    wait_drained("full_drain", 400);

    // Wrap-around stream throttled to at most four buffered.
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (count >= 3'd4 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      wr(i[7:0]);
    end
    wait_drained("wrap_drain", 1000);

    // Write on the same edge as the pop that follows Done.
    hold_done = 1'b1;
    wr(8'h61);
    repeat (3) @(negedge clk);
    wr(8'h62);
    @(negedge clk);
    chk("sim_count_pre", {29'd0, count}, 1);
    @(posedge clk); #1;
    hold_done = 1'b0;
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("sim_done_seen", {31'd0, tx_done}, 1);
    #1;
    wr_dv = 1'b1;
    wr_byte = 8'h63;
    exp_q.push_back(8'h63);
    @(posedge clk); #1;
    wr_dv = 1'b0;
    @(negedge clk);
    chk("sim_count_post", {29'd0, count}, 1);
    chk("sim_dv", {31'd0, tx_dv}, 1);
    chk("sim_byte", {24'd0, tx_byte}, 32'h62);
    wait_drained("sim_drain", 400);

    // Asynchronous reset with three bytes buffered and one in flight.
    hold_done = 1'b1;
    burst(8'h71, 8'h01, 4, 4);
    @(negedge clk);
    chk("mid_count", {29'd0, count}, 3);
    #2 rst_l = 1'b0;
    #1;
    chk("mid_rst_count", {29'd0, count}, 0);
    chk("mid_rst_empty", {31'd0, empty}, 1);
    chk("mid_rst_full", {31'd0, full}, 0);
    chk("mid_rst_dv", {31'd0, tx_dv}, 0);
    chk("mid_rst_byte", {24'd0, tx_byte}, 0);
    chk("mid_rst_ovf", {31'd0, ovf}, 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_l = 1'b1;
    hold_done = 1'b0;
    repeat (TxCyc + 10) @(negedge clk);
    chk("mid_no_stale", {31'd0, empty}, 1);
    wr(8'h5C);
    wait_drained("mid_new_drain", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller sitting directly upstream of `UART_TX`. It accepts bursts of bytes from a host-side producer into a circular FIFO. It then drains them one at a time into the transmitter using the `i_TX_DV` / `o_TX_Done` handshake. This lets producers write at clock rate without tracking UART bit timing.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16); legal range 1–8.

Ports:
- `i_Clock` in 1: system clock; all state on rising edge.
- `i_Rst_L` in 1: reset, asynchronous assert and active-low.
- `i_Wr_DV` in 1: write strobe; one byte per cycle while high.
- `i_Wr_Byte` in 8: write data, sampled when `i_Wr_DV` is high.
- `o_Full` out 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `o_Empty` out 1: FIFO holds 0 bytes.
- `o_Count` out DEPTH_LOG2+1: current occupancy, 0 to 2^DEPTH_LOG2.
- `o_TX_DV` out 1: one-cycle launch pulse to `UART_TX.i_TX_DV`.
- `o_TX_Byte` out 8: byte to `UART_TX.i_TX_Byte`; stable from the launch pulse until the next launch.
- `i_TX_Done` in 1: from `UART_TX.o_TX_Done`; marks the end of the stop bit.
- `o_Overflow` out 1: sticky write-when-full flag (see Configuration).

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array.
  - Write pointer `wp` and read pointer `rp` are DEPTH_LOG2+1 bits, incremented modulo 2^(DEPTH_LOG2+1).
  - Address is the low DEPTH_LOG2 bits.
  - Empty when `wp == rp`. Full when the MSBs differ and the low bits are equal.
  - `o_Count = wp - rp`, truncated to DEPTH_LOG2+1 bits.
- Write: accepted when `i_Wr_DV` is high and `o_Full` is low at that edge. A write attempted while full is dropped; no state changes except `o_Overflow`.
- Drain FSM, three states:
  - IDLE: if not empty, pop at `rp`, register `o_TX_Byte`, assert `o_TX_DV`, increment `rp`, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: deassert `o_TX_DV`, go to WAIT_DONE.
  - WAIT_DONE: on `i_TX_Done` high, go to IDLE. Otherwise stay.
- Simultaneous write and pop on one edge: both take effect. Count is unchanged.
  - Fullness for the write decision uses the pre-edge `o_Full`. A write while full is dropped even if a pop occurs on the same edge.
- `i_TX_Done` is ignored in IDLE and LAUNCH.
- Reset, including mid-transfer:
  - `wp = rp = 0` and FSM returns to IDLE.
  - Buffered bytes are discarded; array contents need not be cleared.
  - A transfer already launched in `UART_TX` is not aborted by this block.

## Timing
- Reset values:
  - `o_Full = 0`, `o_Empty = 1`, `o_Count = 0`
  - `o_TX_DV = 0`, `o_TX_Byte = 8'h00`, `o_Overflow = 0`
- All outputs are registered or derived from registered pointers. There is no combinational path from `i_Wr_DV` to any output.
- Write to an empty FIFO with the FSM in IDLE:
  - Edge k: write is accepted.
  - Edge k+1: pop happens.
  - `o_TX_DV` is high for exactly the cycle following edge k+1.
- Back-to-back bytes: `i_TX_Done` sampled high at edge m gives IDLE. The next `o_TX_DV` is asserted after edge m+1, which matches `UART_TX` returning to idle one cycle after done.
- `o_TX_DV` is never high in two consecutive cycles. Minimum launch spacing is 3 cycles.
- `o_Empty`, `o_Full` and `o_Count` reflect pointer state after the most recent edge.

## Configuration
- Macro: `UART_TX_FIFO_OVF_FLAG_EN`.
- Defined:
  - `o_Overflow` is set on any edge where `i_Wr_DV` is high and `o_Full` is high.
  - It stays high until `i_Rst_L` asserts.
- Not defined: `o_Overflow` is tied to 0 and no overflow logic is synthesized. The port list is identical in both builds.

## Test plan
Bench instantiates `uart_tx_fifo` (DEPTH_LOG2=2) driving `UART_TX` with CLKS_PER_BIT=16, and `UART_RX` on the looped line.
- Single byte: write 8'h3A to empty FIFO at edge k. Required response:
  - `o_TX_DV` high for one cycle after edge k+1 with `o_TX_Byte = 8'h3A`.
  - `UART_RX` reports 8'h3A.
  - `o_Empty` returns to 1.
- Burst: write 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles. Required response:
  - `o_Count` peaks at 3, because the first byte pops at the first edge after its write.
  - RX receives 11, 22, 33, 44 in order.
  - Each launch occurs 1 cycle after the previous `i_TX_Done`.
- Full and drop: hold the FSM in WAIT_DONE, write 5 bytes 8'hA0–8'hA4 with one launched and 4 buffered. Required response:
  - `o_Full = 1` and `o_Count = 4`.
  - The extra write 8'hA5 is dropped; A5 is never transmitted.
  - `o_Overflow = 1` with the macro defined, 0 without.
- Pointer wrap-around: stream 20 bytes 8'h00–8'h13 with writes throttled to keep `o_Count` at most 4. Required response: RX sequence is exact, no loss, across 5 pointer wraps.
- Simultaneous write and pop: with 1 byte buffered and FSM entering IDLE, write on the pop edge. Required response: `o_Count` is unchanged and both bytes are transmitted in order.
- Reset mid-operation: assert `i_Rst_L` low asynchronously while 3 bytes are buffered and the FSM is in WAIT_DONE. Required response:
  - Outputs take reset values immediately, without waiting for an edge.
  - After release, no stale byte is launched.
  - A new write of 8'h5C is transmitted correctly.
